// File: rtl/quiescence_responder.sv
// Per-slot quiescence responder: latches quiesce commands, gates new issues,
// tracks outstanding transactions and answers checks. Optional: QUIESCENCE_RESP_STATUS_EN.
package quiescence_pkg;
   typedef struct packed {
      logic        valid;
      logic        isRequest;
      logic [63:0] data;
   } QuiescenceReq;

   typedef struct packed {
      logic        valid;
      logic [63:0] data;
   } QuiescenceResp;
endpackage

module quiescence_responder
   import quiescence_pkg::*;
#(
   parameter int unsigned OUTSTANDING_W = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  QuiescenceReq  quiescence_req,
   output QuiescenceResp quiescence_resp,
   input  logic          app_issue_valid,
   output logic          app_issue_ok,
   input  logic          app_complete,
   output logic          quiesce_requested,
   output logic          quiesced
);

   typedef enum logic {IDLE, RESPOND} state_t;

   localparam logic [OUTSTANDING_W-1:0] MAX = '1;
   localparam logic [OUTSTANDING_W-1:0] ONE = OUTSTANDING_W'(1);

   state_t                   state_q, state_d;
   logic                     qpend_q, qpend_d;
   logic [OUTSTANDING_W-1:0] outstanding_q, outstanding_d;
   logic                     underflow_q, underflow_d;

   logic        cmd, chk, issue_acc;
   logic [63:0] status;

   assign app_issue_ok      = !qpend_q && (outstanding_q != MAX);
   assign quiesce_requested = qpend_q;
   assign quiesced          = qpend_q && (outstanding_q == '0);

   always_comb begin
      cmd           = quiescence_req.valid && quiescence_req.isRequest;
      chk           = quiescence_req.valid && !quiescence_req.isRequest;
      issue_acc     = app_issue_valid && app_issue_ok;
      qpend_d       = cmd ? quiescence_req.data[0] : qpend_q;
      state_d       = (state_q == IDLE && chk) ? RESPOND : IDLE;
      outstanding_d = outstanding_q;
      underflow_d   = underflow_q;
      // Simultaneous issue and complete cancel; a lone complete at zero is an underflow.
      if (issue_acc && !app_complete) begin
         outstanding_d = outstanding_q + ONE;
      end else if (!issue_acc && app_complete) begin
         if (outstanding_q == '0) begin
            underflow_d = 1'b1;
         end else begin
            outstanding_d = outstanding_q - ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         qpend_q       <= 1'b0;
         outstanding_q <= '0;
         underflow_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         qpend_q       <= qpend_d;
         outstanding_q <= outstanding_d;
         underflow_q   <= underflow_d;
      end
   end

`ifdef QUIESCENCE_RESP_STATUS_EN
   logic [31:0] drain_cycles_q, drain_cycles_d;

   always_comb begin
      drain_cycles_d = drain_cycles_q;
      if (!qpend_q && qpend_d) begin
         drain_cycles_d = '0;
      end else if (qpend_q && outstanding_q != '0 && drain_cycles_q != '1) begin
         drain_cycles_d = drain_cycles_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         drain_cycles_q <= '0;
      end else begin
         drain_cycles_q <= drain_cycles_d;
      end
   end

   always_comb begin
      status                     = '0;
      status[0]                  = quiesced;
      status[1]                  = qpend_q;
      status[2]                  = underflow_q;
      status[16 +: OUTSTANDING_W] = outstanding_q;
      status[63:32]              = drain_cycles_q;
   end
`else
   always_comb begin
      status    = '0;
      status[0] = quiesced;
      status[1] = qpend_q;
      status[2] = underflow_q;
   end
`endif

   always_comb begin
      quiescence_resp.valid = (state_q == RESPOND);
      quiescence_resp.data  = (state_q == RESPOND) ? status : '0;
   end

endmodule

// File: tb/tb_quiescence_responder.sv
// Directed table-driven bench for quiescence_responder (default build), plus a
// narrow-counter instance to exercise the saturation gate on app_issue_ok.
module tb_quiescence_responder;
   import quiescence_pkg::*;

   typedef struct {
      logic        v;
      logic        r;
      logic [63:0] d;
      logic        iss;
      logic        cmp;
      logic        rs;
      logic        ev;
      logic [63:0] ed;
      logic        eok;
      logic        eqr;
      logic        eqd;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   QuiescenceReq  req;
   QuiescenceResp resp;
   logic          issue_v, issue_ok, complete, qreq, qd;

   QuiescenceReq  s_req;
   QuiescenceResp s_resp;
   logic          s_issue_v, s_issue_ok, s_complete, s_qreq, s_qd;

   int unsigned total = 0;
   int unsigned passed = 0;
   vec_t        vecs[$];

   always #5 clk = ~clk;

   quiescence_responder #(.OUTSTANDING_W(16)) dut (
      .clk(clk), .rst(rst), .quiescence_req(req), .quiescence_resp(resp),
      .app_issue_valid(issue_v), .app_issue_ok(issue_ok), .app_complete(complete),
      .quiesce_requested(qreq), .quiesced(qd)
   );

   quiescence_responder #(.OUTSTANDING_W(2)) dut_small (
      .clk(clk), .rst(rst), .quiescence_req(s_req), .quiescence_resp(s_resp),
      .app_issue_valid(s_issue_v), .app_issue_ok(s_issue_ok), .app_complete(s_complete),
      .quiesce_requested(s_qreq), .quiesced(s_qd)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic v, input logic r, input logic [63:0] d,
                               input logic iss, input logic cmp, input logic rs,
                               input logic ev, input logic [63:0] ed,
                               input logic eok, input logic eqr, input logic eqd);
      vec_t t;
      t.v = v; t.r = r; t.d = d; t.iss = iss; t.cmp = cmp; t.rs = rs;
      t.ev = ev; t.ed = ed; t.eok = eok; t.eqr = eqr; t.eqd = eqd;
      return t;
   endfunction

   task automatic check_small(input string name, input logic eok);
      @(negedge clk);
      #1;
      check({name, " small issue_ok"}, 64'(s_issue_ok), 64'(eok));
   endtask

   initial begin
      logic [63:0] ones = '1;
      logic [63:0] ones_but0 = ~64'd1;

      rst = 1'b1;
      req = '0; issue_v = 1'b0; complete = 1'b0;
      s_req = '0; s_issue_v = 1'b0; s_complete = 1'b0;

      //         v  r  data      iss cmp rs  ev ed  ok qr qd
      vecs.push_back(mk(1, 0, 0,         0, 0, 0,  0, 0, 1, 0, 0)); // 0 check at reset
      vecs.push_back(mk(0, 0, 0,         0, 0, 0,  1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0,         1, 0, 0,  0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0,         1, 0, 0,  0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0,         1, 0, 0,  0, 0, 1, 0, 0));
      vecs.push_back(mk(1, 1, 1,         1, 0, 0,  0, 0, 1, 0, 0)); // 5 quiesce + issue still ok
      vecs.push_back(mk(0, 0, 0,         1, 0, 0,  0, 0, 0, 1, 0)); // blocked issue
      vecs.push_back(mk(1, 0, 0,         0, 0, 0,  0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0,         0, 0, 0,  1, 2, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0,         0, 1, 0,  0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0,         0, 1, 0,  0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0,         0, 1, 0,  0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0,         0, 1, 0,  0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0,         0, 0, 0,  0, 0, 0, 1, 1)); // 13 drained
      vecs.push_back(mk(1, 0, 0,         0, 0, 0,  0, 0, 0, 1, 1));
      vecs.push_back(mk(0, 0, 0,         0, 0, 0,  1, 3, 0, 1, 1));
      vecs.push_back(mk(1, 1, 0,         0, 0, 0,  0, 0, 0, 1, 1)); // 16 resume
      vecs.push_back(mk(0, 0, 0,         1, 0, 0,  0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0,         1, 0, 0,  0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0,         1, 1, 0,  0, 0, 1, 0, 0)); // 19 issue+complete
      vecs.push_back(mk(0, 0, 0,         0, 1, 0,  0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0,         0, 1, 0,  0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0,         0, 1, 0,  0, 0, 1, 0, 0)); // 22 underflow
      vecs.push_back(mk(1, 0, 0,         0, 0, 0,  0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0,         0, 0, 0,  1, 4, 1, 0, 0));
      vecs.push_back(mk(1, 1, ones,      0, 0, 0,  0, 0, 1, 0, 0)); // 25 upper bits ignored
      vecs.push_back(mk(1, 0, 0,         0, 0, 0,  0, 0, 0, 1, 1));
      vecs.push_back(mk(0, 0, 0,         0, 0, 0,  1, 7, 0, 1, 1));
      vecs.push_back(mk(1, 1, ones_but0, 0, 0, 0,  0, 0, 0, 1, 1)); // 28 resume
      vecs.push_back(mk(1, 0, 0,         0, 0, 0,  0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0,         0, 0, 0,  1, 4, 1, 0, 0));
      vecs.push_back(mk(1, 0, 0,         0, 0, 0,  0, 0, 1, 0, 0)); // 31 check held
      vecs.push_back(mk(1, 0, 0,         0, 0, 0,  1, 4, 1, 0, 0));
      vecs.push_back(mk(1, 0, 0,         0, 0, 0,  0, 0, 1, 0, 0));
      vecs.push_back(mk(1, 0, 0,         0, 0, 0,  1, 4, 1, 0, 0));
      vecs.push_back(mk(1, 0, 0,         0, 0, 0,  0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0,         0, 0, 0,  1, 4, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0,         0, 0, 0,  0, 0, 1, 0, 0));
      vecs.push_back(mk(1, 1, 1,         1, 0, 0,  0, 0, 1, 0, 0)); // 38
      vecs.push_back(mk(1, 0, 0,         0, 0, 0,  0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0,         0, 0, 1,  1, 6, 0, 1, 0)); // 40 rst during RESPOND
      vecs.push_back(mk(0, 0, 0,         0, 0, 0,  0, 0, 1, 0, 0));
      vecs.push_back(mk(1, 0, 0,         0, 0, 0,  0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0,         0, 0, 0,  1, 0, 1, 0, 0)); // underflow cleared
      vecs.push_back(mk(1, 0, 0,         0, 0, 0,  0, 0, 1, 0, 0));
      vecs.push_back(mk(1, 1, 1,         0, 0, 0,  1, 0, 1, 0, 0)); // 45 command in RESPOND
      vecs.push_back(mk(1, 0, 0,         0, 0, 0,  0, 0, 0, 1, 1));
      vecs.push_back(mk(0, 0, 0,         0, 0, 0,  1, 3, 0, 1, 1));
      vecs.push_back(mk(1, 1, 0,         0, 0, 0,  0, 0, 0, 1, 1));
      vecs.push_back(mk(0, 0, 0,         0, 0, 0,  0, 0, 1, 0, 0));

      repeat (2) @(negedge clk);
      #1;
      check("reset resp_valid", 64'(resp.valid), 64'd0);
      check("reset resp_data", resp.data, 64'd0);
      check("reset issue_ok", 64'(issue_ok), 64'd1);
      check("reset quiesce_requested", 64'(qreq), 64'd0);
      check("reset quiesced", 64'(qd), 64'd0);

      for (int k = 0; k < vecs.size(); k++) begin
         @(negedge clk);
         req.valid     = vecs[k].v;
         req.isRequest = vecs[k].r;
         req.data      = vecs[k].d;
         issue_v       = vecs[k].iss;
         complete      = vecs[k].cmp;
         rst           = vecs[k].rs;
         #1;
         check($sformatf("row%0d resp_valid", k), 64'(resp.valid), 64'(vecs[k].ev));
         check($sformatf("row%0d resp_data", k), resp.data, vecs[k].ed);
         check($sformatf("row%0d issue_ok", k), 64'(issue_ok), 64'(vecs[k].eok));
         check($sformatf("row%0d quiesce_requested", k), 64'(qreq), 64'(vecs[k].eqr));
         check($sformatf("row%0d quiesced", k), 64'(qd), 64'(vecs[k].eqd));
      end

      // Saturation at MAX=3 on the 2-bit instance.
      @(negedge clk);
      req = '0; issue_v = 1'b0; complete = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      s_issue_v = 1'b1;
      #1;
      check("small start issue_ok", 64'(s_issue_ok), 64'd1);
      check_small("cnt1", 1'b1);
      check_small("cnt2", 1'b1);
      check_small("cnt3 at MAX", 1'b0);
      check_small("held at MAX", 1'b0);
      s_issue_v  = 1'b0;
      s_complete = 1'b1;
      #1;
      check("small at MAX before complete", 64'(s_issue_ok), 64'd0);
      check_small("after complete", 1'b1);
      s_complete = 1'b0;
      check("small no underflow resp", 64'(s_resp.valid), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
